// File: rtl/dot_fp_acc_if.sv
// dot_fp_acc_if: operand vectors and registered dot-product result
interface dot_fp_acc_if #(
  parameter int exp_width = 4,
  parameter int man_width = 3,
  parameter int k         = 32
);
  localparam int bit_width = 1 + exp_width + man_width;
  localparam int prd_width = 2 * ((1 << exp_width) + man_width);
  localparam int out_width = prd_width + $clog2(k);
  logic [k-1:0][bit_width-1:0] i_vec_a;
  logic [k-1:0][bit_width-1:0] i_vec_b;
  logic signed [out_width-1:0] o_dp;
  modport master (output i_vec_a, output i_vec_b, input o_dp);
  modport slave  (input i_vec_a, input i_vec_b, output o_dp);
endinterface

// File: rtl/dot_fp_acc.sv
// dot_fp_acc: exact minifloat dot product, fixed-point result in smallest-subnormal-product units
module dot_fp_acc #(
  parameter int exp_width = 4,
  parameter int man_width = 3,
  parameter int k         = 32
) (
  input logic         clk,
  input logic         rst,
  dot_fp_acc_if.slave bus
);
  localparam int bit_width = 1 + exp_width + man_width;
  localparam int prd_width = 2 * ((1 << exp_width) + man_width);
  localparam int out_width = prd_width + $clog2(k);
  localparam int lv        = $clog2(k);
  localparam int ew1       = exp_width + 1;
  logic signed [out_width-1:0] prod [k];
  logic signed [out_width-1:0] dp_d, dp_q;
  for (genvar j = 0; j < k; j++) begin : g_lane
    logic [exp_width-1:0] ea, eb;
    logic [ew1-1:0]       sh;
    logic [out_width-1:0] mag;
    assign ea  = bus.i_vec_a[j][bit_width-2 -: exp_width];
    assign eb  = bus.i_vec_b[j][bit_width-2 -: exp_width];
    // subnormals share the E=1 scale, so each shift is max(E,1)-1
    assign sh  = ew1'(ea) - ew1'(ea != '0) + ew1'(eb) - ew1'(eb != '0);
    assign mag = (out_width'({ea != '0, bus.i_vec_a[j][man_width-1:0]}) *
                  out_width'({eb != '0, bus.i_vec_b[j][man_width-1:0]})) << sh;
    assign prod[j] = (bus.i_vec_a[j][bit_width-1] ^ bus.i_vec_b[j][bit_width-1]) ?
                     -signed'(mag) : signed'(mag);
  end
  // balanced tree; lanes beyond k are padded with zero
  for (genvar i = 0; i <= lv; i++) begin : g_l
    logic signed [out_width-1:0] s [1 << (lv - i)];
    if (i == 0) begin : g_leaf
      for (genvar j = 0; j < (1 << lv); j++) begin : g_j
        if (j < k) begin : g_in
          assign s[j] = prod[j];
        end else begin : g_pad
          assign s[j] = '0;
        end
      end
    end else begin : g_add
      for (genvar j = 0; j < (1 << (lv - i)); j++) begin : g_j
        assign s[j] = g_l[i-1].s[2*j] + g_l[i-1].s[2*j+1];
      end
    end
  end
  always_comb dp_d = g_l[lv].s[0];
  always_ff @(posedge clk) dp_q <= rst ? '0 : dp_d;
  assign bus.o_dp = dp_q;
endmodule

// File: tb/tb_dot_fp_acc.sv
// tb_dot_fp_acc: scoreboard bench for dot_fp_acc with directed and random vectors
module tb_dot_fp_acc;
  localparam int exp_width = 4;
  localparam int man_width = 3;
  localparam int k         = 32;
  typedef logic [k-1:0][7:0] vec_t;
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_run = 0;
  int     n_fail = 0;
  longint sb [$];
  longint got, exp_v;
  dot_fp_acc_if #(.exp_width(exp_width), .man_width(man_width), .k(k)) bus ();
  dot_fp_acc #(.exp_width(exp_width), .man_width(man_width), .k(k)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;

  function automatic longint elem(logic [7:0] x);
    int e;
    longint s, v;
    e = int'(x[6:3]);
    s = longint'(x[2:0]) + ((e != 0) ? 64'sd8 : 64'sd0);
    v = s <<< ((e > 1 ? e : 1) - 1);
    return x[7] ? -v : v;
  endfunction

  function automatic longint dot(vec_t a, vec_t b);
    longint acc = 0;
    for (int j = 0; j < k; j++) acc += elem(a[j]) * elem(b[j]);
    return acc;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < k; j++) v[j] = 8'($urandom);
    return v;
  endfunction

  task automatic apply(input vec_t a, input vec_t b, input logic r);
    bus.i_vec_a = a;
    bus.i_vec_b = b;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      sb.push_back(0);
      apply(rand_vec(), rand_vec(), 1'b1);
      got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
      if (got !== exp_v) begin n_fail++; $display("FAIL reset got %0d expected %0d", got, exp_v); end
    end
    sb.push_back(0);
    apply('0, '0, 1'b0);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL zero_vec got %0d expected %0d", got, exp_v); end
  endtask

  task automatic test_unit_lsb();
    vec_t a = '0, b = '0;
    a[0] = 8'h01; b[0] = 8'h01;
    sb.push_back(1);
    apply(a, b, 1'b0);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL unit_lsb got %0d expected %0d", got, exp_v); end
  endtask

  task automatic test_sign();
    vec_t a = '0, b = '0;
    a[0] = 8'h08; b[0] = 8'h81;
    sb.push_back(-8);
    apply(a, b, 1'b0);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL sign got %0d expected %0d", got, exp_v); end
    a = '0; b = '0; a[k-1] = 8'h80; b[k-1] = 8'h7F;
    sb.push_back(0);
    apply(a, b, 1'b0);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL signed_zero got %0d expected %0d", got, exp_v); end
  endtask

  task automatic test_max();
    vec_t a = '0, b = '0;
    a[0] = 8'h7F; b[0] = 8'h7F;
    sb.push_back(64'sd60397977600);
    apply(a, b, 1'b0);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL max_mag got %0d expected %0d", got, exp_v); end
    for (int j = 0; j < k; j++) begin a[j] = 8'h7F; b[j] = 8'hFF; end
    sb.push_back(-(64'sd7200 <<< 28));
    apply(a, b, 1'b0);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL full_scale_neg got %0d expected %0d", got, exp_v); end
    for (int j = 0; j < k; j++) b[j] = 8'h7F;
    sb.push_back(64'sd7200 <<< 28);
    apply(a, b, 1'b0);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL full_scale_pos got %0d expected %0d", got, exp_v); end
  endtask

  task automatic test_mid_reset();
    vec_t a, b;
    a = rand_vec(); b = rand_vec();
    sb.push_back(dot(a, b));
    apply(a, b, 1'b0);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL pre_reset got %0d expected %0d", got, exp_v); end
    sb.push_back(0);
    apply(rand_vec(), rand_vec(), 1'b1);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL mid_reset got %0d expected %0d", got, exp_v); end
    a = rand_vec(); b = rand_vec();
    sb.push_back(dot(a, b));
    apply(a, b, 1'b0);
    got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
    if (got !== exp_v) begin n_fail++; $display("FAIL post_reset got %0d expected %0d", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    vec_t a, b;
    int fails = 0;
    for (int n = 0; n < 65536; n++) begin
      a = rand_vec(); b = rand_vec();
      sb.push_back(dot(a, b));
      apply(a, b, 1'b0);
      got = longint'(bus.o_dp); exp_v = sb.pop_front(); n_run++;
      if (got !== exp_v) begin
        n_fail++; fails++;
        if (fails <= 10) $display("FAIL random[%0d] got %0d expected %0d", n, got, exp_v);
      end
    end
  endtask

  initial begin
    bus.i_vec_a = '0;
    bus.i_vec_b = '0;
    test_reset();
    test_unit_lsb();
    test_sign();
    test_max();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_fp_acc.md
Name: dot_fp_acc

Overview:
- Exact, non-rounding dot product of two length-k vectors of minifloat elements (sign, exp_width exponent, man_width mantissa; no inf/NaN encodings).
- Result is a signed two's-complement fixed-point integer in units of the smallest subnormal product, i.e. (2^(1-man_width))^2 = 1 LSB.
- Used as the inner-product core of the MX block-format datapath; the shared block scale is applied downstream.

Parameters:
- exp_width, 4, exponent field width.
- man_width, 3, mantissa field width.
- k, 32, vector length (number of element pairs).
- Derived: bit_width = 1+exp_width+man_width.
- Derived: prd_width = 2*((1<<exp_width)+man_width).
- Derived: out_width = prd_width+$clog2(k).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_vec_a  in  k x bit_width  vector A, element j = {sign, exp, man}.
- i_vec_b  in  k x bit_width  vector B, same format.
- o_dp  out  out_width (signed)  registered dot product of A and B.

Behaviour:
- Element decode, for encoding {s, E, M}:
  - Integer significand S = {(E!=0), M}, man_width+1 bits.
  - Shift sh = (E==0) ? 0 : E-1.
  - Magnitude in LSB units = S << sh. E=0 is subnormal, value 2^(1-bias)*0.M; all E values are finite.
  - Real value = (-1)^s * 2^max(E,1) * S * 2^(-man_width), with 2^(1-man_width) = 1 unit.
- Lane product j:
  - Magnitude Sa*Sb << (sha+shb); exact, no truncation or rounding.
  - Sign = sa XOR sb. A zero magnitude gives 0 regardless of sign (no negative zero).
  - Convert to two's complement, sign-extended to out_width.
- Sum all k lane products exactly in out_width bits.
  - Width guarantees no overflow: max |product| < 2^(prd_width-1), and k terms add $clog2(k) bits.
- Pipeline:
  - The adder tree is combinational.
  - Result is captured in a single output register, o_dp.
  - Latency 1 cycle: inputs present before rising edge n appear on o_dp after edge n.
  - Inputs are sampled every cycle; there is no handshake or enable.
- Reset: while rst=1 at a rising edge, o_dp <= 0. The first valid result follows the first edge with rst=0. Reset asserted mid-stream discards that cycle's result.
- k is a power of two ≥ 1; non-power-of-two k is also legal, using the same adder tree with zero padding.

Test Plan:
- Reset: rst=1 for 2 edges with random inputs -> o_dp=0. Deassert, apply all-zero vectors -> o_dp=0 after 1 edge.
- Unit LSB: lane0 a=0x01, b=0x01, other lanes 0 -> o_dp=1.
- Normal/sign: lane0 a=0x08 (=8 units), b=0x81 (=-1 unit) -> o_dp=-8.
- Max magnitude: lane0 a=b=0x7F (S=15, sh=14) -> o_dp=225<<28=60397977600.
- Full-scale negative, no overflow: all 32 lanes a=0x7F, b=0xFF -> o_dp=-(7200<<28).
- Signed zero: a=0x80, b=0x7F -> o_dp=0.
- Random: 65536 cycles of random 8-bit lanes -> o_dp equals the exact real-valued sum computed via the decode formula, normalized by the unit LSB, checked one cycle after each input.
